// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared constants for the multi-cycle main control unit:
//               state encodings, opcodes, ALUOp classes and datapath
//               mux select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  localparam int MC_OP_W = 6;
  localparam int MC_SW_W = 4;

  // State encodings (13 used, 13..15 unused)
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_REXEC  = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp classes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_outdec
// Description : Combinational state-to-strobe decoder for the multi-cycle
//               main control. Pure Moore decode, except that the FETCH
//               strobes irwrite/pcwrite are qualified by mem_ready and the
//               illegal_op pulse looks at the opcode during DECODE.
// Ports       : state (in), mem_ready (in), op (in);
//               aluop, alusrca, alusrcb, pcsource, pcwrite, pcwritecond,
//               iord, memread, memwrite, irwrite, memtoreg, regwrite,
//               regdst, illegal_op (out)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = MC_OP_W,
  parameter int SW_W = MC_SW_W
) (
  input  logic [SW_W-1:0] state,
  input  logic            mem_ready,
  input  logic [OP_W-1:0] op,
  output logic [1:0]      aluop,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsource,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            regdst,
  output logic            illegal_op
);

  always_comb begin
    aluop       = ALUOP_ADD;
    alusrca     = 1'b0;
    alusrcb     = ALUSRCB_B;
    pcsource    = PCSRC_ALU;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        // IR and PC only capture once the memory has delivered the word
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = ALUSRCB_IMMSH;
        illegal_op = ~is_legal_op(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_R;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      default: ; // S_RST and unused encodings drive nothing
    endcase
  end

endmodule : mc_ctrl_outdec
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_control
// Description : Multi-cycle main control FSM. Holds the state register and
//               next-state logic; strobes are decoded by mc_ctrl_outdec.
//               Optional macro MC_PERF_CNT_EN adds instr_count/stall_count.
// Ports       : clk, rst_n, op, mem_ready (in);
//               aluop1/aluop0, alusrca, alusrcb, pcsource, pcwrite,
//               pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
//               regwrite, regdst, illegal_op, [instr_count, stall_count],
//               state_o (out)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = MC_OP_W,
  parameter int SW_W = MC_SW_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            aluop1,
  output logic            aluop0,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsource,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            regdst,
  output logic            illegal_op,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]     instr_count,
  output logic [31:0]     stall_count,
`endif
  output logic [SW_W-1:0] state_o
);

  logic [SW_W-1:0] state_q, state_d;
  logic [1:0]      w_aluop;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_REXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      // S_RST, single-cycle tails and unused encodings all return to FETCH
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  mc_ctrl_outdec #(
    .OP_W (OP_W),
    .SW_W (SW_W)
  ) u_outdec (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .op          (op),
    .aluop       (w_aluop),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsource    (pcsource),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .regdst      (regdst),
    .illegal_op  (illegal_op)
  );

  assign {aluop1, aluop0} = w_aluop;
  assign state_o          = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        w_in_instr;
  logic        w_wait_state;

  // An instruction retires when any post-FETCH state hands back to FETCH;
  // RST, FETCH self-loops and unused encodings are not retirements.
  assign w_in_instr   = (state_q >= S_DECODE) && (state_q <= S_ADDIWB);
  assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

  always_comb begin
    instr_count_d = instr_count_q;
    stall_count_d = stall_count_q;
    if (w_in_instr && (state_d == S_FETCH)) instr_count_d = instr_count_q + 32'd1;
    if (w_wait_state && !mem_ready)         stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule : mc_main_control
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_control
// Description : Scoreboard testbench for mc_main_control. The driver walks
//               instructions phase by phase, pushing the strobes each cycle
//               should show; a negedge monitor pops and compares.
//               Honours MC_PERF_CNT_EN for the counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_control;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       illegal_op;
    logic [3:0] state;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = 6'd0;
  logic        mem_ready = 1'b0;
  logic        aluop1, aluop0, alusrca, pcwrite, pcwritecond, iord, memread;
  logic        memwrite, irwrite, memtoreg, regwrite, regdst, illegal_op;
  logic [1:0]  alusrcb, pcsource;
  logic [3:0]  state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instr_count, stall_count;
  int unsigned exp_instr = 0, exp_stall = 0;
  int unsigned ic_q[$];
  int unsigned sc_q[$];
`endif

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .mem_ready   (mem_ready),
    .aluop1      (aluop1),
    .aluop0      (aluop0),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsource    (pcsource),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .regdst      (regdst),
    .illegal_op  (illegal_op),
`ifdef MC_PERF_CNT_EN
    .instr_count (instr_count),
    .stall_count (stall_count),
`endif
    .state_o     (state_o)
  );

  // Instruction classes: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, 6 illegal
  function automatic int kind_of(input logic [5:0] o);
    case (o)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000: return 5;
      default:   return 6;
    endcase
  endfunction

  // Strobe table for one cycle, written straight from the phase descriptions
  function automatic exp_t expect_for(input logic [3:0] st, input logic mr, input logic ill);
    exp_t e;
    e = '0;
    e.state = st;
    if (st == S_FETCH)  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
    if (st == S_DECODE) begin e.alusrcb = 2'b11; e.illegal_op = ill; end
    if (st == S_MEMADR) begin e.alusrca = 1; e.alusrcb = 2'b10; end
    if (st == S_MEMRD)  begin e.memread = 1; e.iord = 1; end
    if (st == S_MEMWB)  begin e.regwrite = 1; e.memtoreg = 1; end
    if (st == S_MEMWR)  begin e.memwrite = 1; e.iord = 1; end
    if (st == S_REXEC)  begin e.alusrca = 1; e.aluop = 2'b10; end
    if (st == S_RWB)    begin e.regdst = 1; e.regwrite = 1; end
    if (st == S_BEQ)    begin e.alusrca = 1; e.aluop = 2'b01; e.pcwritecond = 1; e.pcsource = 2'b01; end
    if (st == S_JUMP)   begin e.pcwrite = 1; e.pcsource = 2'b10; end
    if (st == S_ADDIEX) begin e.alusrca = 1; e.alusrcb = 2'b10; end
    if (st == S_ADDIWB) begin e.regwrite = 1; end
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = {aluop1, aluop0, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, iord,
         memread, memwrite, irwrite, memtoreg, regwrite, regdst, illegal_op, state_o};
    return a;
  endfunction

  // One clock of stimulus plus its expectation
  task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] opv,
                      input logic ill, input logic rstv, input string tag);
    @(posedge clk);
    #1;
    rst_n     = rstv;
    mem_ready = mr;
    op        = opv;
    exp_q.push_back(expect_for(st, mr, ill));
    tag_q.push_back(tag);
`ifdef MC_PERF_CNT_EN
    ic_q.push_back(exp_instr);
    sc_q.push_back(exp_stall);
    if (rstv && !mr && (st == S_FETCH || st == S_MEMRD || st == S_MEMWR))
      exp_stall++;
`endif
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic reset_cycles(input int n);
`ifdef MC_PERF_CNT_EN
    exp_instr = 0;
    exp_stall = 0;
`endif
    for (int i = 0; i < n; i++) step(S_RST, rnd_bit(), rnd_op(), 1'b0, 1'b0, "reset_low");
    step(S_RST, rnd_bit(), rnd_op(), 1'b0, 1'b1, "reset_release");
  endtask

  task automatic fetch_decode(input logic [5:0] opv, input int fw);
    for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, rnd_op(), 1'b0, 1'b1, "fetch_wait");
    step(S_FETCH, 1'b1, rnd_op(), 1'b0, 1'b1, "fetch");
    step(S_DECODE, rnd_bit(), opv, kind_of(opv) == 6, 1'b1, "decode");
  endtask

  task automatic run_instr(input logic [5:0] opv, input int fw, input int mw);
    fetch_decode(opv, fw);
    case (kind_of(opv))
      0: begin
        step(S_REXEC, rnd_bit(), rnd_op(), 1'b0, 1'b1, "rexec");
        step(S_RWB,   rnd_bit(), rnd_op(), 1'b0, 1'b1, "rwb");
      end
      1: begin
        step(S_MEMADR, rnd_bit(), opv, 1'b0, 1'b1, "memadr_lw");
        for (int i = 0; i < mw; i++) step(S_MEMRD, 1'b0, rnd_op(), 1'b0, 1'b1, "memrd_wait");
        step(S_MEMRD, 1'b1, rnd_op(), 1'b0, 1'b1, "memrd");
        step(S_MEMWB, rnd_bit(), rnd_op(), 1'b0, 1'b1, "memwb");
      end
      2: begin
        step(S_MEMADR, rnd_bit(), opv, 1'b0, 1'b1, "memadr_sw");
        for (int i = 0; i < mw; i++) step(S_MEMWR, 1'b0, rnd_op(), 1'b0, 1'b1, "memwr_wait");
        step(S_MEMWR, 1'b1, rnd_op(), 1'b0, 1'b1, "memwr");
      end
      3: step(S_BEQ,  rnd_bit(), rnd_op(), 1'b0, 1'b1, "beq");
      4: step(S_JUMP, rnd_bit(), rnd_op(), 1'b0, 1'b1, "jump");
      5: begin
        step(S_ADDIEX, rnd_bit(), rnd_op(), 1'b0, 1'b1, "addiex");
        step(S_ADDIWB, rnd_bit(), rnd_op(), 1'b0, 1'b1, "addiwb");
      end
      default: ; // illegal: DECODE returns straight to FETCH
    endcase
`ifdef MC_PERF_CNT_EN
    exp_instr++;
`endif
  endtask

  // Monitor: compare whatever the driver queued for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
      checks++;
      if (memwrite && regwrite) begin
        errors++;
        $display("FAIL mutex_%s: memwrite=%0b regwrite=%0b expected not both", t, memwrite, regwrite);
      end
`ifdef MC_PERF_CNT_EN
      begin
        int unsigned ei, es;
        ei = ic_q.pop_front();
        es = sc_q.pop_front();
        checks++;
        if (instr_count !== ei || stall_count !== es) begin
          errors++;
          $display("FAIL counters_%s: got instr=%0d stall=%0d expected instr=%0d stall=%0d",
                   t, instr_count, stall_count, ei, es);
        end
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    reset_cycles(3);

    // Directed sequences
    run_instr(6'b100011, 0, 0);  // lw, no waits
    run_instr(6'b000000, 0, 0);  // R-type
    run_instr(6'b000100, 0, 0);  // beq
    run_instr(6'b101011, 0, 2);  // sw, two MEMWR waits
    run_instr(6'b111111, 0, 0);  // illegal
    run_instr(6'b000010, 1, 0);  // j with a fetch wait
    run_instr(6'b001000, 0, 0);  // addi

    // Asynchronous reset during a stalled MEMRD
    fetch_decode(6'b100011, 0);
    step(S_MEMADR, rnd_bit(), 6'b100011, 1'b0, 1'b1, "memadr_abort");
    step(S_MEMRD, 1'b0, rnd_op(), 1'b0, 1'b1, "memrd_abort");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (actual() !== expect_for(S_RST, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", actual(), expect_for(S_RST, 1'b0, 1'b0));
    end
`ifdef MC_PERF_CNT_EN
    checks++;
    if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_counters: got instr=%0d stall=%0d expected 0 0", instr_count, stall_count);
    end
`endif
    reset_cycles(2);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      if ($urandom_range(0, 7) < 6) o = ops[$urandom_range(0, 5)];
      else                          o = rnd_op();
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mc_main_control
`default_nettype wire

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM; drives `aluop1`/`aluop0` into the ALU control decoder, which consumes them with the funct field.
- Also drives all datapath strobes: PC, IR, memory, register file and mux selects.
- Replaces the single-cycle combinational main decoder in the multi-cycle datapath, sharing one ALU and one memory port.
- Supports memory wait states through a `mem_ready` handshake.

Parameters:
- `OP_W`, 6, opcode width.
- `SW_W`, 4, state register width.

Ports:
- `clk` input 1 system clock, rising edge.
- `rst_n` input 1 asynchronous active-low reset.
- `op` input 6 `IR[31:26]`, valid from DECODE onward.
- `mem_ready` input 1 memory has completed the current read or write this cycle.
- `aluop1`, `aluop0` output 1 each; ALU op class to the ALU control decoder (00 add, 01 sub, 10 R-type).
- `alusrca` output 1: 0 = PC, 1 = A.
- `alusrcb` output 2: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `pcsource` output 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`, `memtoreg`, `regwrite`, `regdst` output 1 each.
- `illegal_op` output 1: one-cycle pulse on an unsupported opcode.
- `state_o` output `SW_W`: current state, for debug.

Behaviour:
- **Architecture:** Moore FSM with one state register. Outputs are decoded from the state, except the `mem_ready` qualification noted below. Every output not listed for a state is 0.
- **Reset:**
  - `rst_n` low asynchronously forces state S_RST; all outputs are 0 and `state_o` = S_RST.
  - The first clock after release moves S_RST -> S_FETCH unconditionally.
- **S_FETCH:**
  - Outputs: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, aluop=00, `pcsource`=00, `irwrite`=`mem_ready`, `pcwrite`=`mem_ready`.
  - Stays in S_FETCH while `mem_ready`=0; goes to S_DECODE when `mem_ready`=1.
- **S_DECODE:**
  - Outputs: `alusrca`=0, `alusrcb`=11, aluop=00.
  - Next state by `op`:
    - 000000 -> S_REXEC
    - 100011 or 101011 -> S_MEMADR
    - 000100 -> S_BEQ
    - 000010 -> S_JUMP
    - 001000 -> S_ADDIEX
    - any other opcode -> S_FETCH, with `illegal_op`=1 for this cycle only.
- **S_MEMADR:** `alusrca`=1, `alusrcb`=10, aluop=00. Goes to S_MEMRD when `op`=100011, otherwise S_MEMWR.
- **S_MEMRD:** `memread`=1, `iord`=1. Holds while `mem_ready`=0, then -> S_MEMWB.
- **S_MEMWB:** `regwrite`=1, `memtoreg`=1, `regdst`=0. Then -> S_FETCH.
- **S_MEMWR:** `memwrite`=1, `iord`=1, held for the whole wait. Holds while `mem_ready`=0, then -> S_FETCH.
- **S_REXEC:** `alusrca`=1, `alusrcb`=00, aluop=10. Then -> S_RWB.
- **S_RWB:** `regdst`=1, `regwrite`=1, `memtoreg`=0. Then -> S_FETCH.
- **S_BEQ:** `alusrca`=1, `alusrcb`=00, aluop=01, `pcwritecond`=1, `pcsource`=01. Then -> S_FETCH.
- **S_JUMP:** `pcwrite`=1, `pcsource`=10. Then -> S_FETCH.
- **S_ADDIEX:** `alusrca`=1, `alusrcb`=10, aluop=00. Then -> S_ADDIWB.
- **S_ADDIWB:** `regwrite`=1, `regdst`=0, `memtoreg`=0. Then -> S_FETCH.
- **Cycle counts with zero wait states:**
  - lw = 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB)
  - sw = 4; R-type = 4; addi = 4
  - beq = 3; j = 3
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- **Boundary conditions:**
  - `op` is ignored outside S_DECODE and S_MEMADR.
  - Any unused state encoding -> S_FETCH on the next clock, with all outputs 0 in that cycle.
  - Reset asserted mid-instruction aborts it immediately; no strobe is issued after `rst_n` falls.
  - `memwrite` and `regwrite` are never both 1 in the same cycle.

Optional Feature:
- Macro: `MC_PERF_CNT_EN`.
- **When defined:**
  - Adds output `instr_count` (32 bits) and output `stall_count` (32 bits), both reset to 0.
  - `instr_count` increments on every transition into S_FETCH from any state other than S_RST, S_FETCH or an unused encoding. Illegal opcodes are counted.
  - `stall_count` increments each cycle spent in S_FETCH, S_MEMRD or S_MEMWR with `mem_ready`=0.
  - Both counters wrap modulo 2^32.
- **When undefined:** neither port exists and no counter logic is generated.

Decomposition:
- Package `mc_ctrl_pkg` holds:
  - the state encodings S_RST..S_ADDIWB as `SW_W`-bit constants;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - the ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_R=10 shared with the ALU control decoder;
  - the `alusrcb` and `pcsource` select codes.
- One sub-module is natural: `mc_ctrl_outdec`, the purely combinational state-to-outputs decoder. The FSM keeps the state register and next-state logic.

Test Plan:
- **Reset:** hold `rst_n`=0 for 3 cycles, then release -> all outputs 0 while low; `state_o`=S_RST for 1 cycle, then S_FETCH with `memread`=1.
- **lw, zero wait:** `op`=100011, `mem_ready`=1 -> 5 cycles; `regwrite`=1 with `memtoreg`=1 in cycle 5; `pcwrite`=1 only in cycle 1.
- **R-type then beq:** `op`=000000 -> aluop=10 in cycle 3 and `regdst`=`regwrite`=1 in cycle 4; next `op`=000100 -> aluop=01 with `pcwritecond`=1 in cycle 3.
- **Wait states on sw:** `op`=101011 with `mem_ready` low for 2 cycles in S_MEMWR -> `memwrite` held for 3 cycles, instruction takes 6 cycles.
- **Illegal opcode:** `op`=111111 -> `illegal_op`=1 for exactly the DECODE cycle, next state S_FETCH, no `regwrite`/`memwrite`.
- **Async reset mid-MEMRD:** `rst_n` falls mid-cycle -> state S_RST and `memread`=0 immediately; with `MC_PERF_CNT_EN` defined, `instr_count`=0 after reset.
